dot_seq_ctrl: RTL and testbench

DOT_SEQ_CTRL -- requirements
Module: dot_seq_ctrl

---
 rtl/dot_seq_pkg.sv | 17 +
 rtl/dot_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_dot_seq_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_seq_pkg.sv
// Shared types and constants for the dot-product sequencer.
// Holds the FSM state encoding, the optional job counter width and the
// drain counter width.
package dot_seq_pkg;

    localparam int unsigned JOBCNT_W = 16;
    // Drain counter covers macLatency 1..4 (counts 0..macLatency-1).
    localparam int unsigned DRAIN_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/dot_seq_ctrl.sv
// dot_seq_ctrl: sequences one dot-product job over an external MAC datapath.
// It walks the element selector through 0..arraySize-1, pulses clear on the
// first element, waits macLatency cycles for the datapath to settle, then
// captures z into res_data and holds it under a valid/ready handshake.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   start/start_ready   job request; accepted when both high (IDLE only)
//   selector, clear     element index and accumulator-load strobe to datapath
//   z                   datapath accumulator output
//   res_data/res_valid  captured result, held until res_ready
//   res_ready           consumer accepts the result
//   busy                high whenever the FSM is not IDLE
//   job_cnt             (only with DOT_SEQ_JOBCNT_EN) completed-job counter
//
// Build option: define DOT_SEQ_JOBCNT_EN to add the job_cnt output.
module dot_seq_ctrl
    import dot_seq_pkg::*;
#(
    parameter int unsigned arraySize    = 4,
    parameter int unsigned addressWidth = 2,
    parameter int unsigned zBits        = 28,
    parameter int unsigned macLatency   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    start_ready,
    output logic [addressWidth-1:0] selector,
    output logic                    clear,
    input  logic [zBits-1:0]        z,
    output logic [zBits-1:0]        res_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    busy
`ifdef DOT_SEQ_JOBCNT_EN
    ,
    output logic [JOBCNT_W-1:0]     job_cnt
`endif
);

    localparam logic [addressWidth-1:0] LAST_IDX   = addressWidth'(arraySize - 1);
    localparam logic [DRAIN_W-1:0]      LAST_DRAIN = DRAIN_W'(macLatency - 1);

    state_t                  state_q, state_d;
    logic [addressWidth-1:0] cnt_q, cnt_d;
    logic [DRAIN_W-1:0]      dcnt_q, dcnt_d;
    logic                    capture;
    logic                    handshake;

    // Next-state and counter logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        capture   = 1'b0;
        handshake = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && start_ready) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                    dcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + addressWidth'(1);
                end
            end
            DRAIN: begin
                if (dcnt_q == LAST_DRAIN) begin
                    state_d = HOLD;
                    capture = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DRAIN_W'(1);
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d   = IDLE;
                    handshake = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs; outputs are computed from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dcnt_q      <= '0;
            selector    <= '0;
            clear       <= 1'b0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dcnt_q      <= dcnt_d;
            selector    <= (state_d == RUN) ? cnt_d : '0;
            clear       <= (state_d == RUN) && (cnt_d == '0);
            res_valid   <= (state_d == HOLD);
            busy        <= (state_d != IDLE);
            start_ready <= (state_d == IDLE);
            if (capture) begin
                res_data <= z;
            end
        end
    end

`ifdef DOT_SEQ_JOBCNT_EN
    // Completed-job counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            job_cnt <= '0;
        end else if (handshake) begin
            job_cnt <= job_cnt + JOBCNT_W'(1);
        end
    end
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Self-checking bench for dot_seq_ctrl: a default instance (4 elements,
// latency 1) and a larger instance (8 elements, latency 3), each driving a
// behavioural MAC datapath. Expected sums come from plain arithmetic over the
// random operand arrays.
module tb_dot_seq_ctrl;
    import dot_seq_pkg::*;

    localparam int unsigned NA = 4;
    localparam int unsigned LA = 1;
    localparam int unsigned NB = 8;
    localparam int unsigned LB = 3;
    localparam int unsigned ZW = 28;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start_a = 1'b0, res_ready_a = 1'b0;
    logic          start_ready_a, clear_a, res_valid_a, busy_a;
    logic [1:0]    sel_a;
    logic [ZW-1:0] z_a, res_data_a;

    logic          start_b = 1'b0, res_ready_b = 1'b0;
    logic          start_ready_b, clear_b, res_valid_b, busy_b;
    logic [2:0]    sel_b;
    logic [ZW-1:0] z_b, res_data_b;

`ifdef DOT_SEQ_JOBCNT_EN
    logic [15:0] job_cnt_a, job_cnt_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int hs_a     = 0;
    int hs_b     = 0;

    int unsigned va_a[NA], vb_a[NA], va_b[NB], vb_b[NB];

    dot_seq_ctrl #(.arraySize(NA), .addressWidth(2), .zBits(ZW), .macLatency(LA)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .start_ready(start_ready_a),
        .selector(sel_a), .clear(clear_a), .z(z_a), .res_data(res_data_a),
        .res_valid(res_valid_a), .res_ready(res_ready_a), .busy(busy_a)
`ifdef DOT_SEQ_JOBCNT_EN
        , .job_cnt(job_cnt_a)
`endif
    );

    dot_seq_ctrl #(.arraySize(NB), .addressWidth(3), .zBits(ZW), .macLatency(LB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .start_ready(start_ready_b),
        .selector(sel_b), .clear(clear_b), .z(z_b), .res_data(res_data_b),
        .res_valid(res_valid_b), .res_ready(res_ready_b), .busy(busy_b)
`ifdef DOT_SEQ_JOBCNT_EN
        , .job_cnt(job_cnt_b)
`endif
    );

    // Datapath A: z reflects the presented element one cycle later.
    always @(posedge clk) begin
        if (clear_a) z_a <= ZW'(64'(va_a[sel_a]) * 64'(vb_a[sel_a]));
        else         z_a <= z_a + ZW'(64'(va_a[sel_a]) * 64'(vb_a[sel_a]));
    end

    // Datapath B: two pipeline stages before the accumulator -> 3 cycles.
    logic [2:0] s1_b, s2_b;
    logic       c1_b, c2_b;
    always @(posedge clk) begin
        s1_b <= sel_b;
        c1_b <= clear_b;
        s2_b <= s1_b;
        c2_b <= c1_b;
        if (c2_b) z_b <= ZW'(64'(va_b[s2_b]) * 64'(vb_b[s2_b]));
        else      z_b <= z_b + ZW'(64'(va_b[s2_b]) * 64'(vb_b[s2_b]));
    end

    task automatic fill_a(input int unsigned maxv);
        for (int i = 0; i < int'(NA); i++) begin
            va_a[i] = $urandom_range(maxv, 0);
            vb_a[i] = $urandom_range(maxv, 0);
        end
    endtask

    task automatic fill_b(input int unsigned maxv);
        for (int i = 0; i < int'(NB); i++) begin
            va_b[i] = $urandom_range(maxv, 0);
            vb_b[i] = $urandom_range(maxv, 0);
        end
    endtask

    function automatic logic [ZW-1:0] ref_a();
        longint unsigned s = 0;
        for (int i = 0; i < int'(NA); i++) s += 64'(va_a[i]) * 64'(vb_a[i]);
        return ZW'(s);
    endfunction

    function automatic logic [ZW-1:0] ref_b();
        longint unsigned s = 0;
        for (int i = 0; i < int'(NB); i++) s += 64'(va_b[i]) * 64'(vb_b[i]);
        return ZW'(s);
    endfunction

    // Runs one job on A from accept through the first res_valid cycle,
    // checking the per-cycle selector/clear/status profile; leaves A in HOLD.
    task automatic job_a(input logic [ZW-1:0] exp, input string tag);
        int k = 0;
        logic [5:0] got, want;
        while (start_ready_a !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (start_ready_a !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready: got %b want 1", tag, start_ready_a);
        end
        start_a = 1'b1;
        for (int c = 1; c <= int'(NA + LA + 1); c++) begin
            @(negedge clk);
            start_a = 1'b0;
            got  = {sel_a, clear_a, busy_a, start_ready_a, res_valid_a};
            want = {(c <= int'(NA)) ? 2'(c - 1) : 2'd0, c == 1, 1'b1, 1'b0,
                    c == int'(NA + LA + 1)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s_cycle%0d {sel,clr,busy,rdy,vld}: got %b want %b",
                         tag, c, got, want);
            end
        end
        n_checks++;
        if (res_data_a !== exp) begin
            n_fail++;
            $display("FAIL %s_data: got %h want %h", tag, res_data_a, exp);
        end
    endtask

    task automatic handshake_a(input string tag);
        res_ready_a = 1'b1;
        @(negedge clk);
        res_ready_a = 1'b0;
        hs_a++;
        n_checks++;
        if ({res_valid_a, start_ready_a, busy_a, sel_a, clear_a} !== 6'b010000) begin
            n_fail++;
            $display("FAIL %s_release {vld,rdy,busy,sel,clr}: got %b want 010000", tag,
                     {res_valid_a, start_ready_a, busy_a, sel_a, clear_a});
        end
    endtask

    task automatic test_reset;
        #3 rst = 1'b0;
        #1;
        n_checks++;
        if ({start_ready_a, busy_a, sel_a, clear_a, res_valid_a} !== 6'd0 || res_data_a !== '0 ||
            {start_ready_b, busy_b, sel_b, clear_b, res_valid_b} !== 7'd0 || res_data_b !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got a=%b/%h b=%b/%h want zeros",
                     {start_ready_a, busy_a, sel_a, clear_a, res_valid_a}, res_data_a,
                     {start_ready_b, busy_b, sel_b, clear_b, res_valid_b}, res_data_b);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (start_ready_a !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: got rdy=%b busy=%b want 0 0", start_ready_a, busy_a);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({start_ready_a, busy_a, res_valid_a} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_idle {rdy,busy,vld}: got %b want 100",
                     {start_ready_a, busy_a, res_valid_a});
        end
    endtask

    task automatic test_single_job;
        fill_a(255);
        job_a(ref_a(), "single");
        handshake_a("single");
    endtask

    // Result must stay put while unacknowledged; start pulses are ignored.
    task automatic test_hold;
        logic [ZW-1:0] exp;
        fill_a(255);
        exp = ref_a();
        job_a(exp, "hold");
        for (int c = 0; c < 10; c++) begin
            start_a = 1'($urandom_range(1, 0));
            @(negedge clk);
            n_checks++;
            if ({res_valid_a, start_ready_a, busy_a} !== 3'b101 || res_data_a !== exp) begin
                n_fail++;
                $display("FAIL hold_%0d {vld,rdy,busy}/data: got %b/%h want 101/%h", c,
                         {res_valid_a, start_ready_a, busy_a}, res_data_a, exp);
            end
        end
        start_a = 1'b0;
        handshake_a("hold");
    endtask

    task automatic test_back_to_back;
        int rises[$];
        int k = 0;
        logic [ZW-1:0] exp;
        fill_a(255);
        exp = ref_a();
        while (start_ready_a !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        start_a     = 1'b1;
        res_ready_a = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (res_valid_a === 1'b1) begin
                rises.push_back(c);
                hs_a++;
                n_checks++;
                if (res_data_a !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_data%0d: got %h want %h", rises.size(), res_data_a, exp);
                end
                fill_a(255);
                exp = ref_a();
                if (rises.size() == 4) start_a = 1'b0;
            end
        end
        res_ready_a = 1'b0;
        n_checks++;
        if (rises.size() != 4 || rises[0] != int'(NA + LA + 1)) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d rises first@%0d want 4 first@%0d",
                     rises.size(), (rises.size() > 0) ? rises[0] : -1, NA + LA + 1);
        end
        for (int i = 1; i < rises.size(); i++) begin
            n_checks++;
            if (rises[i] - rises[i-1] != int'(NA + LA + 2)) begin
                n_fail++;
                $display("FAIL b2b_spacing%0d: got %0d want %0d", i,
                         rises[i] - rises[i-1], NA + LA + 2);
            end
        end
    endtask

    task automatic test_reset_midrun;
        int k = 0;
        bit stray = 1'b0;
        fill_a(255);
        while (start_ready_a !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({start_ready_a, busy_a, sel_a, clear_a, res_valid_a} !== 6'd0 || start_ready_b !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_async {rdy,busy,sel,clr,vld}: got %b rdy_b=%b want 000000 0",
                     {start_ready_a, busy_a, sel_a, clear_a, res_valid_a}, start_ready_b);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (res_valid_a !== 1'b0 || busy_a !== 1'b0) stray = 1'b1;
        end
        n_checks++;
        if (stray) begin
            n_fail++;
            $display("FAIL midrun_abandon: got stray valid/busy want none");
        end
        fill_a(255);
        job_a(ref_a(), "fresh");
        handshake_a("fresh");
    endtask

    // Operands near 14 bits push the sum past 2^28, exercising full-width capture.
    task automatic test_wide;
        fill_a(16383);
        job_a(ref_a(), "wide");
        handshake_a("wide");
    endtask

    task automatic test_long;
        int k = 0;
        logic [ZW-1:0] exp;
        logic [6:0] got, want;
        fill_b(255);
        exp = ref_b();
        while (start_ready_b !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        start_b = 1'b1;
        for (int c = 1; c <= int'(NB + LB + 1); c++) begin
            @(negedge clk);
            start_b = 1'b0;
            got  = {sel_b, clear_b, busy_b, start_ready_b, res_valid_b};
            want = {(c <= int'(NB)) ? 3'(c - 1) : 3'd0, c == 1, 1'b1, 1'b0,
                    c == int'(NB + LB + 1)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL long_cycle%0d {sel,clr,busy,rdy,vld}: got %b want %b", c, got, want);
            end
        end
        n_checks++;
        if (res_data_b !== exp) begin
            n_fail++;
            $display("FAIL long_data: got %h want %h", res_data_b, exp);
        end
        res_ready_b = 1'b1;
        @(negedge clk);
        res_ready_b = 1'b0;
        hs_b++;
        n_checks++;
        if ({res_valid_b, start_ready_b, busy_b} !== 3'b010) begin
            n_fail++;
            $display("FAIL long_release {vld,rdy,busy}: got %b want 010",
                     {res_valid_b, start_ready_b, busy_b});
        end
    endtask

`ifdef DOT_SEQ_JOBCNT_EN
    task automatic test_jobcnt;
        n_checks++;
        if (job_cnt_a !== 16'(hs_a) || job_cnt_b !== 16'(hs_b)) begin
            n_fail++;
            $display("FAIL jobcnt: got %0d/%0d want %0d/%0d", job_cnt_a, job_cnt_b, hs_a, hs_b);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single_job;
        test_hold;
        test_back_to_back;
        test_reset_midrun;
        test_wide;
        test_long;
`ifdef DOT_SEQ_JOBCNT_EN
        test_jobcnt;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
